// File: rtl/carrd_issue_ctrl.sv
// Carrd vector issue sequencer: FIFO-buffers base-processor instructions, issues one at a time.
// Push->DECODE in 2 cycles; instr_ready drops only when the FIFO holds FIFO_DEPTH entries.
module carrd_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int SLDU_LAT   = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] issue_instr,
  input  logic        dec_is_vconfig,
  input  logic [3:0]  dec_alu_op,
  input  logic        dec_is_mul,
  input  logic [3:0]  dec_lsu_op,
  input  logic [2:0]  dec_sldu_op,
  input  logic [2:0]  dec_red_op,
  input  logic [1:0]  dec_sel_dest,
  input  logic        done_vlanes,
  input  logic        done_vred,
  output logic        start_vlanes,
  output logic        start_vred,
  output logic        csr_wr_en,
  output logic        v_reg_wr_en,
  output logic        x_reg_wr_en,
  output logic        busy,
  output logic        illegal_instr,
  output logic        timeout_err,
  output logic [15:0] retired
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] SLDU_LAST = 8'(SLDU_LAT - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_WB} state_e;
  typedef enum logic [1:0] {C_LANES, C_RED, C_SLDU} cls_e;

  state_e        state_q, state_d;
  cls_e          cls_q, cls_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   retired_q, retired_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   issue_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, unit_done;
  logic          unused_lsu;

  // LSU ops are deliberately unsupported; they fall through to the illegal class.
  assign unused_lsu = ^dec_lsu_op;

  assign instr_ready = (count_q < CW'(FIFO_DEPTH));
  assign push        = instr_valid && instr_ready;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign issue_instr = issue_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign timeout_err = timeout_q;
  assign retired     = retired_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      issue_q   <= '0;
      state_q   <= S_IDLE;
      cls_q     <= C_LANES;
      cnt_q     <= '0;
      retired_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        issue_q  <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    unit_done = 1'b0;
    case (cls_q)
      C_LANES: unit_done = done_vlanes;
      C_RED:   unit_done = done_vred;
      C_SLDU:  unit_done = (cnt_q == SLDU_LAST);
      default: unit_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cnt_d         = cnt_q;
    retired_d     = retired_q;
    timeout_d     = timeout_q;
    start_vlanes  = 1'b0;
    start_vred    = 1'b0;
    csr_wr_en     = 1'b0;
    v_reg_wr_en   = 1'b0;
    x_reg_wr_en   = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_DECODE;
      end
      S_DECODE: begin
        cnt_d = '0;
        if (dec_is_vconfig) begin
          csr_wr_en = 1'b1;
          retired_d = retired_q + 16'd1;
          state_d   = S_IDLE;
        end else if (dec_red_op != '0) begin
          start_vred = 1'b1;
          cls_d      = C_RED;
          state_d    = S_WAIT;
        end else if (dec_sldu_op != '0) begin
          cls_d   = C_SLDU;
          state_d = S_WAIT;
        end else if ((dec_alu_op != '0) || dec_is_mul) begin
          start_vlanes = 1'b1;
          cls_d        = C_LANES;
          state_d      = S_WAIT;
        end else begin
          illegal_instr = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Completion takes priority over a coincident timeout.
        if (unit_done) begin
          state_d = S_WB;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WB: begin
        v_reg_wr_en = (dec_sel_dest == 2'd1);
        x_reg_wr_en = (dec_sel_dest == 2'd2);
        retired_d   = retired_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_carrd_issue_ctrl.sv
// Bench for carrd_issue_ctrl: decoder/unit models plus an in-order outcome scoreboard.
module tb_carrd_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] issue_instr;
  logic        dec_is_vconfig, dec_is_mul;
  logic [3:0]  dec_alu_op, dec_lsu_op;
  logic [2:0]  dec_sldu_op, dec_red_op;
  logic [1:0]  dec_sel_dest;
  logic        done_vlanes = 1'b0, done_vred = 1'b0;
  logic        start_vlanes, start_vred, csr_wr_en, v_reg_wr_en, x_reg_wr_en;
  logic        busy, illegal_instr, timeout_err;
  logic [15:0] retired;

  carrd_issue_ctrl #(.FIFO_DEPTH(4), .SLDU_LAT(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .issue_instr(issue_instr),
    .dec_is_vconfig(dec_is_vconfig), .dec_alu_op(dec_alu_op), .dec_is_mul(dec_is_mul),
    .dec_lsu_op(dec_lsu_op), .dec_sldu_op(dec_sldu_op), .dec_red_op(dec_red_op),
    .dec_sel_dest(dec_sel_dest), .done_vlanes(done_vlanes), .done_vred(done_vred),
    .start_vlanes(start_vlanes), .start_vred(start_vred), .csr_wr_en(csr_wr_en),
    .v_reg_wr_en(v_reg_wr_en), .x_reg_wr_en(x_reg_wr_en), .busy(busy),
    .illegal_instr(illegal_instr), .timeout_err(timeout_err), .retired(retired)
  );

  always #5 clk = ~clk;

  // Outcome codes: 0 csr, 1 vector wb, 2 scalar wb, 4 illegal, 5 timeout.
  typedef struct {logic [31:0] ins; int outcome;} sb_t;
  sb_t sb_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int last_t;
  int n_start_l, n_start_r, n_csr, n_vwb, n_xwb, n_ill;
  int t_start_l, t_start_r, t_csr, t_vwb, t_xwb, t_ill, t_to;
  int lanes_dly = 3, red_dly = 2, l_cd = 0, r_cd = 0;
  bit hold_lanes = 1'b0;
  logic to_prev = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(int tag, int kind, int sel);
    return {tag[15:0], 10'd0, sel[1:0], 1'b0, kind[2:0]};
  endfunction

  function automatic int exp_of(logic [31:0] i);
    if (i[2:0] == 3'd5) return 0;
    if (i[2:0] == 3'd0) return 4;
    return (i[5:4] == 2'd1) ? 1 : 2;
  endfunction

  // Decoder model: kind in [2:0], destination in [5:4].
  always_comb begin
    dec_is_vconfig = 1'b0;
    dec_alu_op     = 4'd0;
    dec_is_mul     = 1'b0;
    dec_lsu_op     = 4'd0;
    dec_sldu_op    = 3'd0;
    dec_red_op     = 3'd0;
    dec_sel_dest   = issue_instr[5:4];
    case (issue_instr[2:0])
      3'd0:    dec_lsu_op = 4'd1;
      3'd1:    dec_alu_op = 4'd1;
      3'd2:    dec_is_mul = 1'b1;
      3'd3:    dec_red_op = 3'd1;
      3'd4:    dec_sldu_op = 3'd1;
      3'd5:    dec_is_vconfig = 1'b1;
      default: dec_alu_op = 4'd0;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Execution unit model: done pulse a fixed number of cycles after start.
  always @(negedge clk) begin
    done_vlanes = 1'b0;
    done_vred   = 1'b0;
    if (l_cd > 0) begin
      l_cd--;
      if (l_cd == 0 && !hold_lanes) done_vlanes = 1'b1;
    end
    if (r_cd > 0) begin
      r_cd--;
      if (r_cd == 0) done_vred = 1'b1;
    end
    if (start_vlanes && !rst) l_cd = lanes_dly;
    if (start_vred && !rst) r_cd = red_dly;
  end

  always @(negedge clk) begin
    int ev;
    sb_t e;
    if (!rst) begin
      ev = -1;
      if (start_vlanes) begin n_start_l++; t_start_l = cyc; end
      if (start_vred)   begin n_start_r++; t_start_r = cyc; end
      if (csr_wr_en)     begin n_csr++; t_csr = cyc; ev = 0; end
      if (v_reg_wr_en)   begin n_vwb++; t_vwb = cyc; ev = 1; end
      if (x_reg_wr_en)   begin n_xwb++; t_xwb = cyc; ev = 2; end
      if (illegal_instr) begin n_ill++; t_ill = cyc; ev = 4; end
      if (timeout_err && !to_prev) begin t_to = cyc; ev = 5; end
      if (ev >= 0) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_outcome", ev, e.outcome);
          chk("sb_instr", issue_instr, e.ins);
        end
      end
    end
    to_prev = timeout_err;
  end

  task automatic clear_stats();
    n_start_l = 0; n_start_r = 0; n_csr = 0; n_vwb = 0; n_xwb = 0; n_ill = 0;
    t_start_l = -1; t_start_r = -1; t_csr = -1; t_vwb = -1; t_xwb = -1; t_ill = -1; t_to = -1;
  endtask

  task automatic push_instr(logic [31:0] ins, int outcome);
    sb_t e;
    int g = 0;
    @(negedge clk);
    while (!instr_ready && g < 200) begin
      instr_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    if (!instr_ready) chk("push_ready_timeout", 32'(instr_ready), 32'd1);
    instr_in    = ins;
    instr_valid = 1'b1;
    last_t      = cyc;
    e.ins = ins; e.outcome = outcome;
    sb_q.push_back(e);
  endtask

  task automatic release_valid();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int g = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("quiet_busy", 32'(busy), 32'd0);
    chk("quiet_drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [15:0] r0;
    rst = 1'b1; instr_valid = 1'b0; instr_in = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_issue", issue_instr, 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_pulses", 32'({start_vlanes, start_vred, csr_wr_en, v_reg_wr_en, x_reg_wr_en, illegal_instr}), 32'd0);

    // Single ALU op, vector destination
    clear_stats(); r0 = retired;
    push_instr(mk(1, 1, 1), 1); t0 = last_t;
    release_valid();
    wait_quiet();
    chk("alu_start_cyc", t_start_l - t0, 32'd2);
    chk("alu_vwb_cyc", t_vwb - t0, 32'd6);
    chk("alu_vwb_cnt", n_vwb, 32'd1);
    chk("alu_retired", 32'(16'(retired - r0)), 32'd1);

    // Back-to-back pushes into a stalled pipe
    clear_stats(); r0 = retired; lanes_dly = 6;
    for (int i = 0; i < 5; i++) push_instr(mk(10 + i, 1 + (i % 2), 1 + (i % 2)), 1 + (i % 2));
    release_valid();
    chk("full_ready", 32'(instr_ready), 32'd0);
    push_instr(mk(15, 1, 1), 1);
    release_valid();
    wait_quiet();
    chk("b2b_retired", 32'(16'(retired - r0)), 32'd6);
    chk("b2b_wb_cnt", n_vwb + n_xwb, 32'd6);
    lanes_dly = 3;

    // vconfig then reduction with scalar destination
    clear_stats(); r0 = retired;
    push_instr(mk(20, 5, 0), 0); t0 = last_t;
    push_instr(mk(21, 3, 2), 2);
    release_valid();
    wait_quiet();
    chk("cfg_csr_cnt", n_csr, 32'd1);
    chk("cfg_csr_cyc", t_csr - t0, 32'd2);
    chk("red_start_cnt", n_start_r, 32'd1);
    chk("red_start_cyc", t_start_r - t0, 32'd4);
    chk("red_xwb_cnt", n_xwb, 32'd1);
    chk("red_xwb_cyc", t_xwb - t0, 32'd7);
    chk("red_vwb_cnt", n_vwb, 32'd0);
    chk("cfg_red_retired", 32'(16'(retired - r0)), 32'd2);

    // Slide op: fixed latency, no unit start
    clear_stats();
    push_instr(mk(30, 4, 1), 1); t0 = last_t;
    release_valid();
    wait_quiet();
    chk("sldu_starts", n_start_l + n_start_r, 32'd0);
    chk("sldu_vwb_cyc", t_vwb - t0, 32'd4);
    chk("sldu_vwb_cnt", n_vwb, 32'd1);

    // LSU op is dropped
    clear_stats(); r0 = retired;
    push_instr(mk(40, 0, 1), 4); t0 = last_t;
    release_valid();
    wait_quiet();
    chk("lsu_ill_cnt", n_ill, 32'd1);
    chk("lsu_ill_cyc", t_ill - t0, 32'd2);
    chk("lsu_enables", n_start_l + n_start_r + n_csr + n_vwb + n_xwb, 32'd0);
    chk("lsu_retired", 32'(16'(retired - r0)), 32'd0);

    // Lanes op never completes; queued reduction must still run
    clear_stats(); r0 = retired; hold_lanes = 1'b1;
    push_instr(mk(50, 1, 1), 5); t0 = last_t;
    push_instr(mk(51, 3, 1), 1);
    release_valid();
    wait_quiet();
    hold_lanes = 1'b0;
    chk("to_cyc", t_to - t0, 32'd11);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    chk("to_retired", 32'(16'(retired - r0)), 32'd1);
    chk("to_next_vwb", n_vwb, 32'd1);
    repeat (5) @(negedge clk);
    chk("to_still_set", 32'(timeout_err), 32'd1);

    // Reset mid-WAIT with entries queued
    clear_stats(); lanes_dly = 6;
    push_instr(mk(60, 1, 1), 1);
    push_instr(mk(61, 1, 1), 1);
    push_instr(mk(62, 1, 1), 1);
    release_valid();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    clear_stats();
    repeat (12) @(negedge clk);
    chk("post_rst_vwb", n_vwb, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/carrd_issue_ctrl.md
# carrd_issue_ctrl

Instruction issue sequencer for the Carrd vector coprocessor. It buffers vector instructions arriving from the base processor in a small FIFO and presents one instruction at a time to v_decoder. It then launches the selected execution unit (v_lanes, v_red, v_sldu, or the vcsr write), waits for completion or a fixed latency, and produces the single-cycle writeback enables. It sits between the base-processor instruction port and the carrd_integrated datapath, replacing the direct `op_instr_base` feed.

## Interface
- FIFO_DEPTH, 4: instruction buffer entries, power of two, 2..16.
- SLDU_LAT, 1: fixed cycles v_sldu needs after issue, 1..15.
- TIMEOUT, 255: maximum WAIT cycles before abort, 1..255.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_in  in  32  instruction from base processor.
- instr_valid  in  1  instr_in valid.
- instr_ready  out  1  FIFO can accept this cycle.
- issue_instr  out  32  instruction held for v_decoder and operand muxes.
- dec_is_vconfig  in  1  from v_decoder.
- dec_alu_op  in  4  from v_decoder; nonzero means an ALU op.
- dec_is_mul  in  1  from v_decoder.
- dec_lsu_op  in  4  from v_decoder.
- dec_sldu_op  in  3  from v_decoder.
- dec_red_op  in  3  from v_decoder.
- dec_sel_dest  in  2  from v_decoder: 1 = vector dest, 2 = scalar dest.
- done_vlanes  in  1  v_lanes completion pulse.
- done_vred  in  1  v_red completion pulse.
- start_vlanes  out  1  one-cycle launch of v_lanes.
- start_vred  out  1  one-cycle launch of v_red.
- csr_wr_en  out  1  one-cycle vcsr write.
- v_reg_wr_en  out  1  one-cycle vector regfile write.
- x_reg_wr_en  out  1  one-cycle scalar writeback.
- busy  out  1  state is not IDLE, or the FIFO is non-empty.
- illegal_instr  out  1  one-cycle pulse when an instruction is dropped.
- timeout_err  out  1  sticky; set on timeout, cleared only by rst.
- retired  out  16  count of completed instructions, wraps 0xFFFF→0.

## Operation
- FIFO
  - Push when instr_valid && instr_ready.
  - instr_ready = (count < FIFO_DEPTH), from registered count only; when full, a same-cycle pop does not enable a push.
  - Pop only from IDLE.
- States: IDLE, DECODE, WAIT, WB.
- IDLE
  - FIFO empty: remain in IDLE.
  - Else: pop the head into the issue_instr register and go to DECODE.
- DECODE (one cycle). Classify from the decoder inputs in this priority order:
  1. vconfig: csr_wr_en=1, retired+1, go to IDLE.
  2. red (dec_red_op≠0): start_vred=1, go to WAIT.
  3. sldu (dec_sldu_op≠0): clear the cycle counter, go to WAIT.
  4. lanes (dec_alu_op≠0 or dec_is_mul): start_vlanes=1, go to WAIT.
  5. Anything else, including LSU (unsupported here): illegal_instr=1, go to IDLE, retired unchanged.
- WAIT
  - The cycle counter (8 bit) is cleared on entry and increments each cycle.
  - lanes class: done_vlanes goes to WB.
  - red class: done_vred goes to WB.
  - sldu class: counter == SLDU_LAT-1 goes to WB.
  - Done from the non-selected unit is ignored.
  - counter == TIMEOUT-1 without completion: set timeout_err, go to IDLE, no writeback, retired unchanged.
  - If completion and timeout occur in the same cycle, completion wins.
- WB (one cycle)
  - v_reg_wr_en = (dec_sel_dest==1).
  - x_reg_wr_en = (dec_sel_dest==2).
  - retired+1, go to IDLE.
- start_*, csr_wr_en, v/x_reg_wr_en and illegal_instr are decoded combinationally from state and class, and are never high outside their state.
- The instruction class is latched in DECODE and used in WAIT and WB.
- issue_instr holds its value from the pop until the next pop.

## Timing
- Reset values:
  - State IDLE, FIFO empty, count 0, instr_ready 1.
  - issue_instr 0, counter 0, retired 0, timeout_err 0, busy 0.
  - All pulse outputs 0.
- rst in any state (including mid-WAIT) discards the FIFO and the in-flight instruction, with no writeback. Done pulses arriving afterwards are ignored.
- Latency: push at cycle 0 → IDLE pops at cycle 1 → DECODE at cycle 2 (start pulse) → WAIT from cycle 3.
- vconfig: csr_wr_en at cycle 2; the next instruction's DECODE is at cycle 4 at the earliest.
- sldu: WB at cycle 3+SLDU_LAT.
- Done sampled in WAIT at cycle N → WB at N+1 → IDLE at N+2, which may pop the next entry the same cycle.
- A done pulse during DECODE is not captured; units must respond at least one cycle after start.

## Test plan
- Single ALU op (dec_alu_op=1, sel_dest=1), done_vlanes 3 cycles after start → start_vlanes at cycle 2, v_reg_wr_en exactly one cycle at cycle 6, retired=1.
- 5 back-to-back pushes with FIFO_DEPTH=4 while the first op is stalled → instr_ready low after 4 queued entries; all 5 retire in order; no entry lost or duplicated.
- vconfig then reduction (sel_dest=2) with done_vred after 2 cycles → csr_wr_en one pulse; start_vred one pulse; x_reg_wr_en one pulse; v_reg_wr_en never high; retired=2.
- SLDU op with SLDU_LAT=1 → no start_*; v_reg_wr_en at cycle 4.
- LSU op (dec_lsu_op=1, others 0) → illegal_instr one pulse at cycle 2, no enables, retired=0. Lanes op with done withheld, TIMEOUT=8 → timeout_err set after 8 WAIT cycles and stays set; the next queued op proceeds normally.
- rst asserted mid-WAIT with 2 entries queued → next cycle: IDLE, busy=0, instr_ready=1; a later done_vlanes produces no writeback.
